// File: rtl/cache_fill_controller.sv
// rtl/cache_fill_controller.sv - direct-mapped write-through cache with integrated line-fill FSM
`timescale 1ns/1ps
module cache_fill_controller #(
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 16,
   parameter int LINE_WORDS = 8,
   parameter int NUM_SETS   = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_req,
   input  logic              cpu_write,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ready,
   output logic              mem_req,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_rvalid
);
   localparam int OFF_W = $clog2(LINE_WORDS);
   localparam int IDX_W = $clog2(NUM_SETS);
   localparam int TAG_W = ADDR_W - OFF_W - IDX_W;
   localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(LINE_WORDS - 1);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_FILL = 1'b1;

   logic [DATA_W-1:0] data_mem [0:NUM_SETS*LINE_WORDS-1];
   logic [TAG_W-1:0]  tag_mem  [0:NUM_SETS-1];
   logic [NUM_SETS-1:0] valid;

   logic [0:0]       state;
   logic [OFF_W-1:0] issue_cnt;
   logic [OFF_W-1:0] recv_cnt;
   logic             issue_done;
   logic [TAG_W-1:0] fill_tag;
   logic [IDX_W-1:0] fill_idx;

   logic [OFF_W-1:0] cpu_off;
   logic [IDX_W-1:0] cpu_idx;
   logic [TAG_W-1:0] cpu_tag;
   logic             hit;
   logic             read_miss;
   logic             write_done;
   logic             fill_accept;
   logic             fill_rvalid;

   assign cpu_off = cpu_addr[OFF_W-1:0];
   assign cpu_idx = cpu_addr[OFF_W +: IDX_W];
   assign cpu_tag = cpu_addr[ADDR_W-1 -: TAG_W];

   assign hit         = cpu_req & valid[cpu_idx] & (tag_mem[cpu_idx] == cpu_tag);
   assign read_miss   = (state == S_IDLE) & cpu_req & ~cpu_write & ~hit;
   assign write_done  = (state == S_IDLE) & cpu_req & cpu_write & mem_ready;
   assign fill_accept = (state == S_FILL) & ~issue_done & mem_ready;
   assign fill_rvalid = (state == S_FILL) & mem_rvalid;

   // Outputs are gated by rst_n so they fall to zero the moment reset asserts.
   always_comb begin
      cpu_ready = 1'b0;
      cpu_rdata = '0;
      mem_req   = 1'b0;
      mem_write = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (rst_n) begin
         if (state == S_IDLE) begin
            if (cpu_req && cpu_write) begin
               mem_req   = 1'b1;
               mem_write = 1'b1;
               mem_addr  = cpu_addr;
               mem_wdata = cpu_wdata;
               cpu_ready = mem_ready;
            end else if (hit) begin
               cpu_ready = 1'b1;
               cpu_rdata = data_mem[{cpu_idx, cpu_off}];
            end
         end else begin
            mem_req  = ~issue_done;
            mem_addr = {fill_tag, fill_idx, issue_cnt};
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         valid      <= '0;
         issue_cnt  <= '0;
         recv_cnt   <= '0;
         issue_done <= 1'b0;
         fill_tag   <= '0;
         fill_idx   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               // Invalidate up front so a fill cut short by reset can never hit.
               if (read_miss) begin
                  valid[cpu_idx] <= 1'b0;
                  fill_tag       <= cpu_tag;
                  fill_idx       <= cpu_idx;
                  issue_cnt      <= '0;
                  recv_cnt       <= '0;
                  issue_done     <= 1'b0;
                  state          <= S_FILL;
               end
            end
            S_FILL: begin
               if (fill_accept) begin
                  issue_cnt <= issue_cnt + OFF_W'(1);
                  if (issue_cnt == LAST_WORD) issue_done <= 1'b1;
               end
               if (mem_rvalid) begin
                  recv_cnt <= recv_cnt + OFF_W'(1);
                  if (recv_cnt == LAST_WORD) begin
                     valid[fill_idx] <= 1'b1;
                     issue_done      <= 1'b0;
                     state           <= S_IDLE;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (write_done && hit) data_mem[{cpu_idx, cpu_off}] <= cpu_wdata;
      if (fill_rvalid) begin
         data_mem[{fill_idx, recv_cnt}] <= mem_rdata;
         if (recv_cnt == LAST_WORD) tag_mem[fill_idx] <= fill_tag;
      end
   end
endmodule

// File: tb/tb_cache_fill_controller.sv
// tb/tb_cache_fill_controller.sv - self-checking bench for cache_fill_controller
`timescale 1ns/1ps
module tb_cache_fill_controller;
   typedef struct {
      bit          wr;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] rdata;
      bit          miss;
      int          hold;
   } vec_t;
   typedef struct {
      bit          wr;
      logic [15:0] addr;
      logic [15:0] data;
   } mt_t;
   typedef struct {
      logic [15:0] addr;
      int          due;
   } pend_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cpu_req = 1'b0;
   logic        cpu_write = 1'b0;
   logic [15:0] cpu_addr = '0;
   logic [15:0] cpu_wdata = '0;
   logic [15:0] cpu_rdata;
   logic        cpu_ready;
   logic        mem_req;
   logic        mem_write;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_ready = 1'b1;
   logic [15:0] mem_rdata = '0;
   logic        mem_rvalid = 1'b0;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int acc_cnt = 0;
   int rv_seen = 0;
   int last_rv_cyc = 0;
   int hold_low = 0;
   bit ready_toggle = 1'b0;
   bit rv_burst = 1'b0;
   bit spurious = 1'b0;

   mt_t         exp_mem_q [$];
   logic [15:0] exp_rd_q [$];
   pend_t       pend [$];
   logic [15:0] bk [logic [15:0]];
   vec_t        tbl [13];

   cache_fill_controller dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
      .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
   );

   initial forever #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [15:0] rd(input logic [15:0] a);
      if (bk.exists(a)) return bk[a];
      if (a[15:3] == 13'h0008) return 16'h1000 + {13'h0, a[2:0]};
      return a ^ 16'hA5A5;
   endfunction

   // Memory model: accepts checked against the expected-transaction queue, reads return after 2 cycles.
   initial begin
      mt_t   e;
      pend_t p;
      forever begin
         @(negedge clk);
         if (rst_n && mem_rvalid) begin
            rv_seen++;
            last_rv_cyc = cyc;
         end
         if (rst_n && mem_req && mem_ready) begin
            acc_cnt++;
            if (exp_mem_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_mem_txn: got addr %h write %b expected none", mem_addr, mem_write);
            end else begin
               e = exp_mem_q.pop_front();
               chk("mem_write", 32'(mem_write), 32'(e.wr));
               chk("mem_addr", 32'(mem_addr), 32'(e.addr));
               if (e.wr) chk("mem_wdata", 32'(mem_wdata), 32'(e.data));
            end
            if (mem_write) bk[mem_addr] = mem_wdata;
            else pend.push_back('{mem_addr, cyc + 2});
         end
         @(posedge clk);
         #1;
         if (!rst_n) begin
            pend.delete();
            mem_rvalid = 1'b0;
         end else if (spurious) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 16'hDEAD;
            spurious   = 1'b0;
         end else if (pend.size() > 0 && pend[0].due <= cyc && (!rv_burst || (cyc % 4) < 2)) begin
            p = pend.pop_front();
            mem_rvalid = 1'b1;
            mem_rdata  = rd(p.addr);
         end else begin
            mem_rvalid = 1'b0;
         end
         if (hold_low > 0) begin
            mem_ready = 1'b0;
            hold_low--;
         end else begin
            mem_ready = ready_toggle ? cyc[0] : 1'b1;
         end
      end
   end

   task automatic start_access(input vec_t v);
      @(negedge clk);
      hold_low = v.hold;
      if (v.wr) exp_mem_q.push_back('{1'b1, v.addr, v.wdata});
      else if (v.miss)
         for (int i = 0; i < 8; i++) exp_mem_q.push_back('{1'b0, {v.addr[15:3], 3'(i)}, 16'h0});
      if (!v.wr) exp_rd_q.push_back(v.rdata);
      @(posedge clk);
      #1;
      cpu_req   = 1'b1;
      cpu_write = v.wr;
      cpu_addr  = v.addr;
      cpu_wdata = v.wdata;
   endtask

   task automatic finish_access(input vec_t v, input int acc0);
      int   waited = 0;
      bit   done = 1'b0;
      logic [15:0] exp_d;
      while (!done && waited < 300) begin
         @(negedge clk);
         if (cpu_ready) done = 1'b1;
         else waited++;
      end
      if (!v.wr) exp_d = exp_rd_q.pop_front();
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL timeout: no cpu_ready for addr %h after %0d cycles", v.addr, waited);
         exp_mem_q.delete();
      end else begin
         if (!v.wr) chk("cpu_rdata", 32'(cpu_rdata), 32'(exp_d));
         if (v.wr) chk("write_stall", waited, v.hold);
         else if (!v.miss) chk("hit_latency", waited, 0);
         else chk("fill_latency", cyc, last_rv_cyc + 1);
      end
      @(posedge clk);
      #1;
      cpu_req = 1'b0;
      chk("mem_accepts", acc_cnt - acc0, v.wr ? 1 : (v.miss ? 8 : 0));
      chk("mem_q_empty", exp_mem_q.size(), 0);
   endtask

   task automatic do_access(input vec_t v);
      int acc0;
      acc0 = acc_cnt;
      start_access(v);
      finish_access(v, acc0);
   endtask

   task automatic check_outputs_zero(input string tag);
      chk({tag, "_cpu_ready"}, 32'(cpu_ready), 0);
      chk({tag, "_cpu_rdata"}, 32'(cpu_rdata), 0);
      chk({tag, "_mem_req"},   32'(mem_req), 0);
      chk({tag, "_mem_write"}, 32'(mem_write), 0);
      chk({tag, "_mem_addr"},  32'(mem_addr), 0);
      chk({tag, "_mem_wdata"}, 32'(mem_wdata), 0);
   endtask

   initial begin
      vec_t v;
      int   rv0;
      int   acc0;
      int   n;

      tbl[0]  = '{1'b0, 16'h0040, 16'h0000, 16'h1000, 1'b1, 0};
      tbl[1]  = '{1'b0, 16'h0043, 16'h0000, 16'h1003, 1'b0, 0};
      tbl[2]  = '{1'b1, 16'h0042, 16'hBEEF, 16'h0000, 1'b0, 3};
      tbl[3]  = '{1'b0, 16'h0042, 16'h0000, 16'hBEEF, 1'b0, 0};
      tbl[4]  = '{1'b1, 16'h0200, 16'h1234, 16'h0000, 1'b0, 0};
      tbl[5]  = '{1'b0, 16'h0200, 16'h0000, 16'h1234, 1'b1, 0};
      tbl[6]  = '{1'b0, 16'h0207, 16'h0000, 16'hA7A2, 1'b0, 0};
      tbl[7]  = '{1'b0, 16'h0440, 16'h0000, 16'hA1E5, 1'b1, 0};
      tbl[8]  = '{1'b0, 16'h0447, 16'h0000, 16'hA1E2, 1'b0, 0};
      tbl[9]  = '{1'b0, 16'h0040, 16'h0000, 16'h1000, 1'b1, 0};
      tbl[10] = '{1'b0, 16'h0042, 16'h0000, 16'hBEEF, 1'b0, 0};
      tbl[11] = '{1'b1, 16'h0045, 16'h5555, 16'h0000, 1'b0, 1};
      tbl[12] = '{1'b0, 16'h0045, 16'h0000, 16'h5555, 1'b0, 0};

      #3;
      check_outputs_zero("reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_outputs_zero("idle");

      foreach (tbl[i]) do_access(tbl[i]);

      // Reset in the middle of a fill, request held throughout.
      v = '{1'b0, 16'h0080, 16'h0000, 16'hA525, 1'b1, 0};
      start_access(v);
      rv0 = rv_seen;
      n = 0;
      while (rv_seen < rv0 + 3 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("midfill_rvalids", rv_seen - rv0, 3);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_outputs_zero("async_rst");
      repeat (2) @(negedge clk);
      exp_mem_q.delete();
      for (int i = 0; i < 8; i++) exp_mem_q.push_back('{1'b0, 16'h0080 + 16'(i), 16'h0});
      acc0 = acc_cnt;
      rst_n = 1'b1;
      finish_access(v, acc0);

      // Throttled fill: ready toggles, responses arrive in bursts.
      ready_toggle = 1'b1;
      rv_burst = 1'b1;
      do_access('{1'b0, 16'h00C8, 16'h0000, 16'hA56D, 1'b1, 0});
      ready_toggle = 1'b0;
      rv_burst = 1'b0;
      for (int i = 1; i < 8; i++)
         do_access('{1'b0, 16'h00C8 + 16'(i), 16'h0000, (16'h00C8 + 16'(i)) ^ 16'hA5A5, 1'b0, 0});

      // Stray response while idle must be ignored.
      @(negedge clk);
      spurious = 1'b1;
      n = 0;
      while (!mem_rvalid && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("spurious_seen", 32'(mem_rvalid), 1);
      chk("spurious_mem_req", 32'(mem_req), 0);
      chk("spurious_cpu_ready", 32'(cpu_ready), 0);
      repeat (2) @(negedge clk);
      do_access('{1'b0, 16'h00CA, 16'h0000, 16'hA56F, 1'b0, 0});
      do_access('{1'b0, 16'h0083, 16'h0000, 16'hA526, 1'b0, 0});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
      $fatal(1);
   end
endmodule

// File: doc/cache_fill_controller.md
Name: cache_fill_controller

Overview:
- Parametrised direct-mapped cache with an integrated miss/fill state machine; replaces the separate cache, controller mux and miss-FSM arrangement with one block.
- Sits between the CPU pipeline (fetch or data port) and the shared memory interface.
- Read hits return the same cycle.
- Read misses stall the CPU, burst-fill a whole line from memory, then replay as a hit.
- Writes are write-through, no-write-allocate.

Parameters:
- ADDR_W, 16, word address width.
- DATA_W, 16, data word width.
- LINE_WORDS, 8, words per line; power of 2, ≥2.
- NUM_SETS, 8, number of lines; power of 2, ≥2.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_req  in  1  CPU access request; held with addr/data until cpu_ready.
- cpu_write  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  word address.
- cpu_wdata  in  DATA_W  write data.
- cpu_rdata  out  DATA_W  read data, valid when cpu_ready and read.
- cpu_ready  out  1  access complete this cycle.
- mem_req  out  1  memory request valid.
- mem_write  out  1  1 = memory write, 0 = read.
- mem_addr  out  ADDR_W  memory word address.
- mem_wdata  out  DATA_W  memory write data.
- mem_ready  in  1  memory accepts request this cycle (mem_req & mem_ready).
- mem_rdata  in  DATA_W  read return data.
- mem_rvalid  in  1  read return valid; in-order, one per accepted read.

Behaviour:
- Address split: offset = low log2(LINE_WORDS) bits; index = next log2(NUM_SETS) bits; tag = remaining bits.
- Storage: data array NUM_SETS×LINE_WORDS×DATA_W; tag array with one valid bit per set.
- Data and tag arrays are not reset. Valid bits clear on reset.
- Reset values: cpu_ready=0, cpu_rdata=0, mem_req=0, mem_write=0, mem_addr=0, mem_wdata=0. State=IDLE; both counters 0.
- hit = cpu_req & valid[index] & (tag match). Combinational.
- State IDLE:
  - Read hit: cpu_ready=1 and cpu_rdata=word same cycle (0-cycle latency).
  - Read miss: cpu_ready=0. Next edge: clear valid[index], latch line base address, go to FILL.
  - Write (hit or miss): mem_req=1, mem_write=1, mem_addr=cpu_addr, mem_wdata=cpu_wdata, driven combinationally.
  - Write completes when mem_ready=1: cpu_ready=1 that cycle. On that edge, if hit, the cached word is updated. A write miss never allocates.
  - Write with mem_ready=0: stall, no array change.
- State FILL:
  - issue_cnt drives mem_req=1, mem_write=0, mem_addr={tag,index,issue_cnt}. Increments on each accept. mem_req drops once LINE_WORDS reads are issued.
  - recv_cnt increments on each mem_rvalid; mem_rdata is written to word recv_cnt of the line.
  - Issue and receive overlap freely. Responses may arrive the same cycle as an accept.
  - On the last rvalid (recv_cnt=LINE_WORDS-1): write tag, set valid, go to IDLE. The next cycle the held request hits.
  - cpu_ready=0 throughout FILL.
- mem_rvalid outside FILL is ignored.
- Counters are log2(LINE_WORDS) bits wide and wrap to 0 at line end.
- Fill address wraps naturally inside the line. It never carries into the index.
- CPU must hold cpu_req/addr/wdata stable while cpu_ready=0. Changes mid-stall are undefined.
- Reset mid-fill: immediate return to IDLE with all valid bits clear. The partially filled line is never hit because its valid bit was cleared at fill start. Any memory responses still in flight after reset are ignored.
- cpu_req=0: cpu_ready=0, mem_req=0 in IDLE.

Test Plan:
- Defaults: offset=[2:0], index=[5:3], tag=[15:6].
- Cold read miss: reset, read 0x0040 → eight reads 0x0040..0x0047. Memory returns 0x1000+i after 2 cycles. The cycle after the 8th rvalid, cpu_ready=1 with rdata=0x1000. Then read 0x0043 → cpu_ready same cycle, rdata=0x1003, no mem_req.
- Write hit with backpressure: after the fill, write 0x0042=0xBEEF with mem_ready low 3 cycles → cpu_ready=0 for 3 cycles, then 1 with mem_addr=0x0042 and mem_wdata=0xBEEF. Read 0x0042 then hits with 0xBEEF.
- Write miss: write 0x0200=0x1234 → one memory write, no fill. Subsequent read 0x0200 misses and fills 0x0200..0x0207.
- Conflict eviction: fill 0x0040, then read 0x0440 (same index 0) → fill 0x0440..0x0447. A re-read of 0x0040 misses again.
- Reset mid-fill: assert rst_n=0 after 3 rvalids of a fill → all outputs 0 asynchronously. After release, read of the same address misses and issues a full 8-word fill from word 0.
- Fill throttling: mem_ready toggles 1/0 during the fill, rvalid arrives in bursts, and a spurious rvalid occurs in IDLE → exactly 8 accepted reads, line contents correct, no state change from the spurious rvalid.
